// File: rtl/io_input_controller.sv
// Board key/switch input block: synchronize, debounce, latch events into
// pending interrupt flags, expose them as CPU registers at 0xFFFA-0xFFFD.
module io_input_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  buttons,
  input  logic [9:0]  switches,
  input  logic [17:0] addr,
  input  logic        oe,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_drive,
  output logic [7:0]  interruptions,
  output logic        irq
);

  localparam int N = 14;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] A_MASK = 16'hFFFA;
  localparam logic [15:0] A_PEND = 16'hFFFB;
  localparam logic [15:0] A_SW   = 16'hFFFC;
  localparam logic [15:0] A_KEY  = 16'hFFFD;

  logic [N-1:0]     raw;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     stable;
  logic [N-1:0]     accept;
  logic [CNT_W-1:0] cnt [N];
  logic [4:0]       pending;
  logic [4:0]       mask;
  logic [4:0]       set;
  logic [4:0]       clr;
  logic             wr_pend;
  logic             wr_mask;
  logic             hit;
  logic [15:0]      rdata;
  logic [15:0]      a16;
  logic             unused_bits;

  // Keys are inverted on entry so a cleared flop reads as released.
  assign raw = {switches, ~buttons};
  assign a16 = addr[15:0];
  assign unused_bits = ^{addr[17:16], data_in[15:5]};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < N; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++)
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == LAST);
  end

  assign set     = {|accept[13:4], accept[3:0] & s2[3:0]};
  assign wr_pend = oe && (a16 == A_PEND);
  assign wr_mask = oe && (a16 == A_MASK);
  assign clr     = wr_pend ? data_in[4:0] : 5'd0;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr) | set;
      if (wr_mask) mask <= data_in[4:0];
    end
  end

  always_comb begin
    hit   = 1'b1;
    rdata = 16'h0000;
    case (a16)
      A_KEY:   rdata = {12'b0, stable[3:0]};
      A_SW:    rdata = {6'b0, stable[13:4]};
      A_PEND:  rdata = {11'b0, pending};
      A_MASK:  rdata = {11'b0, mask};
      default: hit   = 1'b0;
    endcase
  end

  assign data_drive    = hit & ~oe;
  assign data_out      = data_drive ? rdata : 16'h0000;
  assign interruptions = {3'b0, pending & mask};
  assign irq           = |interruptions;

endmodule
